bus_master_arbiter: RTL and testbench

- Shares the single device-bus master interface (dev_access_*) between the CPU instruction-fetch port (ibus) and the load/store port (dbus).
- Sits between the pipeline's IF/MEM stages and data_bus.
- Sequences each access: grant, hold through device stall, capture read data, one-cycle ack.
- Arbitration is data-priority with a starvation limit for instruction fetch.

---
 rtl/bus_master_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_master_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Shares one device-bus master port between instruction fetch (ibus) and load/store (dbus).
// Data requests win by default; a fetch held off for MAX_DATA_BURST data grants is forced through.
module bus_master_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_addr,
  input  logic        ibus_read,
  output logic [31:0] ibus_rdata,
  output logic        ibus_ack,
  output logic        ibus_stall,
  input  logic [31:0] dbus_addr,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,
  output logic        dbus_stall,
  output logic [31:0] dev_access_addr,
  output logic        dev_access_read,
  output logic        dev_access_write,
  output logic [31:0] dev_access_write_data,
  input  logic [31:0] dev_access_read_data,
  input  logic        data_bus_stall
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

  localparam logic [3:0] MAX_BURST = 4'(MAX_DATA_BURST);

  state_e      state_q, state_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        ibus_ack_q, ibus_ack_d;
  logic        dbus_ack_q, dbus_ack_d;
  logic [31:0] ibus_rdata_q, ibus_rdata_d;
  logic [31:0] dbus_rdata_q, dbus_rdata_d;
  logic        i_req, d_req, i_starved, d_is_write;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // A master's own ack masks its request so a still-high request is not re-issued.
  assign i_req      = ibus_read & ~ibus_ack_q;
  assign d_req      = (dbus_read | dbus_write) & ~dbus_ack_q;
  assign i_starved  = i_req & (burst_cnt_q >= MAX_BURST);
  assign d_is_write = dbus_write;

  always_comb begin
    state_d               = state_q;
    burst_cnt_d           = burst_cnt_q;
    ibus_ack_d            = 1'b0;
    dbus_ack_d            = 1'b0;
    ibus_rdata_d          = ibus_rdata_q;
    dbus_rdata_d          = dbus_rdata_q;
    dev_access_addr       = '0;
    dev_access_read       = 1'b0;
    dev_access_write      = 1'b0;
    dev_access_write_data = '0;
    case (state_q)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_d     = GRANT_D;
          burst_cnt_d = i_req ? sat_inc(burst_cnt_q) : 4'd0;
        end else if (i_req) begin
          state_d     = GRANT_I;
          burst_cnt_d = 4'd0;
        end
      end
      GRANT_I: begin
        dev_access_addr = ibus_addr;
        dev_access_read = 1'b1;
        if (!data_bus_stall) begin
          ibus_rdata_d = dev_access_read_data;
          ibus_ack_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      GRANT_D: begin
        // Read and write together resolve as a store.
        dev_access_addr       = dbus_addr;
        dev_access_write      = d_is_write;
        dev_access_read       = dbus_read & ~d_is_write;
        dev_access_write_data = dbus_wdata;
        if (!data_bus_stall) begin
          if (!d_is_write) dbus_rdata_d = dev_access_read_data;
          dbus_ack_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd0;
      ibus_ack_q   <= 1'b0;
      dbus_ack_q   <= 1'b0;
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      ibus_ack_q   <= ibus_ack_d;
      dbus_ack_q   <= dbus_ack_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_rdata_q <= dbus_rdata_d;
    end
  end

  assign ibus_ack   = ibus_ack_q;
  assign dbus_ack   = dbus_ack_q;
  assign ibus_rdata = ibus_rdata_q;
  assign dbus_rdata = dbus_rdata_q;
  assign ibus_stall = ibus_read & ~ibus_ack_q;
  assign dbus_stall = (dbus_read | dbus_write) & ~dbus_ack_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: expected bus transfers and acked read data go into
// scoreboard queues; a negedge monitor pops them as the DUT completes transfers and acks.
module tb_bus_master_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ibus_addr = '0;
  logic        ibus_read = 1'b0;
  logic [31:0] ibus_rdata;
  logic        ibus_ack, ibus_stall;
  logic [31:0] dbus_addr = '0;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [31:0] dbus_wdata = '0;
  logic [31:0] dbus_rdata;
  logic        dbus_ack, dbus_stall;
  logic [31:0] dev_access_addr;
  logic        dev_access_read, dev_access_write;
  logic [31:0] dev_access_write_data;
  logic [31:0] dev_rd = '0;
  logic        data_bus_stall = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  bus_t        q_bus[$];
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  bus_t        mon_b;
  logic [31:0] mon_v;

  always #5 clk = ~clk;

  bus_master_arbiter #(.MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .ibus_addr(ibus_addr), .ibus_read(ibus_read), .ibus_rdata(ibus_rdata),
    .ibus_ack(ibus_ack), .ibus_stall(ibus_stall),
    .dbus_addr(dbus_addr), .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .dbus_stall(dbus_stall),
    .dev_access_addr(dev_access_addr), .dev_access_read(dev_access_read),
    .dev_access_write(dev_access_write), .dev_access_write_data(dev_access_write_data),
    .dev_access_read_data(dev_rd), .data_bus_stall(data_bus_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic r, input logic w, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.rd = r; b.wr = w; b.wdata = wd;
    q_bus.push_back(b);
  endtask

  // Monitor: a bus transfer completes on a granted cycle without stall; acks carry read data.
  always @(negedge clk) begin
    if (!rst) begin
      if ((dev_access_read || dev_access_write) && !data_bus_stall) begin
        if (q_bus.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bus_unexpected: got addr %h rd %b wr %b, expected no transfer",
                   dev_access_addr, dev_access_read, dev_access_write);
        end else begin
          mon_b = q_bus.pop_front();
          chk("bus_addr", dev_access_addr, mon_b.addr);
          chk1("bus_read", dev_access_read, mon_b.rd);
          chk1("bus_write", dev_access_write, mon_b.wr);
          if (mon_b.wr) chk("bus_wdata", dev_access_write_data, mon_b.wdata);
        end
      end
      if (ibus_ack) begin
        if (q_i.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ibus_ack_unexpected: got ack 1, expected 0");
        end else begin
          mon_v = q_i.pop_front();
          chk("ibus_rdata", ibus_rdata, mon_v);
        end
      end
      if (dbus_ack) begin
        if (q_d.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dbus_ack_unexpected: got ack 1, expected 0");
        end else begin
          mon_v = q_d.pop_front();
          chk("dbus_rdata", dbus_rdata, mon_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_dev_read", dev_access_read, 1'b0);
    chk1("rst_dev_write", dev_access_write, 1'b0);
    chk("rst_dev_addr", dev_access_addr, 32'h0);
    chk1("rst_ibus_ack", ibus_ack, 1'b0);
    chk1("rst_dbus_ack", dbus_ack, 1'b0);
    chk("rst_ibus_rdata", ibus_rdata, 32'h0);
    chk("rst_dbus_rdata", dbus_rdata, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Single fetch: bus driven one cycle after the request, ack the cycle after
    ibus_addr = 32'h1E00_0010; ibus_read = 1'b1; dev_rd = 32'hDEAD_BEEF;
    push_bus(32'h1E00_0010, 1'b1, 1'b0, 32'h0); q_i.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk1("fetch_c0_dev_read", dev_access_read, 1'b0);
    chk1("fetch_c0_stall", ibus_stall, 1'b1);
    step();
    @(negedge clk);
    chk1("fetch_c1_dev_read", dev_access_read, 1'b1);
    chk("fetch_c1_addr", dev_access_addr, 32'h1E00_0010);
    step();
    ibus_read = 1'b0;
    @(negedge clk);
    chk1("fetch_c2_ack", ibus_ack, 1'b1);
    chk("fetch_c2_rdata", ibus_rdata, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk1("fetch_c3_ack", ibus_ack, 1'b0);
    chk1("fetch_c3_dev_read", dev_access_read, 1'b0);

    // Simultaneous requests: dbus first, ibus right after the dbus ack
    step();
    ibus_addr = 32'h1E00_0020; ibus_read = 1'b1;
    dbus_addr = 32'h0000_0200; dbus_read = 1'b1; dev_rd = 32'h0BAD_F00D;
    push_bus(32'h0000_0200, 1'b1, 1'b0, 32'h0); q_d.push_back(32'h0BAD_F00D);
    step();
    @(negedge clk);
    chk("simul_c1_addr", dev_access_addr, 32'h0000_0200);
    step();
    dbus_read = 1'b0; dev_rd = 32'hCAFE_F00D;
    push_bus(32'h1E00_0020, 1'b1, 1'b0, 32'h0); q_i.push_back(32'hCAFE_F00D);
    @(negedge clk);
    chk1("simul_c2_dbus_ack", dbus_ack, 1'b1);
    chk1("simul_c2_dev_read", dev_access_read, 1'b0);
    step();
    @(negedge clk);
    chk("simul_c3_addr", dev_access_addr, 32'h1E00_0020);
    step();
    ibus_read = 1'b0;
    @(negedge clk);
    chk1("simul_c4_ibus_ack", ibus_ack, 1'b1);
    step();

    // Stall hold: store held 4 cycles, pending fetch waits, store leaves dbus_rdata alone
    dbus_addr = 32'h0000_0100; dbus_wdata = 32'h1234_5678; dbus_write = 1'b1;
    ibus_addr = 32'h1E00_0030; ibus_read = 1'b1; data_bus_stall = 1'b1;
    push_bus(32'h0000_0100, 1'b0, 1'b1, 32'h1234_5678); q_d.push_back(32'h0BAD_F00D);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) data_bus_stall = 1'b0;
      @(negedge clk);
      chk1("stall_dev_write", dev_access_write, 1'b1);
      chk1("stall_dev_read", dev_access_read, 1'b0);
      chk1("stall_dbus_ack", dbus_ack, 1'b0);
    end
    step();
    dbus_write = 1'b0; dev_rd = 32'h1111_2222;
    push_bus(32'h1E00_0030, 1'b1, 1'b0, 32'h0); q_i.push_back(32'h1111_2222);
    @(negedge clk);
    chk1("stall_ack", dbus_ack, 1'b1);
    chk("stall_rdata_kept", dbus_rdata, 32'h0BAD_F00D);
    step();
    step();
    ibus_read = 1'b0;
    step();

    // Read and write together: resolved as a write
    dbus_addr = 32'h0000_0204; dbus_wdata = 32'hA5A5_A5A5;
    dbus_read = 1'b1; dbus_write = 1'b1;
    push_bus(32'h0000_0204, 1'b0, 1'b1, 32'hA5A5_A5A5); q_d.push_back(32'h0BAD_F00D);
    step();
    @(negedge clk);
    chk1("rw_dev_write", dev_access_write, 1'b1);
    chk1("rw_dev_read", dev_access_read, 1'b0);
    step();
    dbus_read = 1'b0; dbus_write = 1'b0;
    step();

    // Starvation limit: fetch re-raised at each data arbitration point; 5th pick goes to ibus
    dbus_addr = 32'h0000_0300; dbus_read = 1'b1; ibus_addr = 32'h1E00_0040;
    for (int k = 0; k < 4; k++) begin
      ibus_read = 1'b1; dev_rd = 32'h100 + 32'(k);
      push_bus(32'h0000_0300, 1'b1, 1'b0, 32'h0); q_d.push_back(32'h100 + 32'(k));
      step();
      @(negedge clk);
      chk("starve_d_addr", dev_access_addr, 32'h0000_0300);
      step();
      ibus_read = 1'b0;
      step();
    end
    ibus_read = 1'b1; dev_rd = 32'h200;
    push_bus(32'h1E00_0040, 1'b1, 1'b0, 32'h0); q_i.push_back(32'h200);
    step();
    @(negedge clk);
    chk("starve_i_addr", dev_access_addr, 32'h1E00_0040);
    step();
    ibus_read = 1'b0; dev_rd = 32'h104;
    push_bus(32'h0000_0300, 1'b1, 1'b0, 32'h0); q_d.push_back(32'h104);
    step();
    @(negedge clk);
    chk("resume_d_addr", dev_access_addr, 32'h0000_0300);
    step();
    dbus_read = 1'b0;
    step();

    // Reset mid-access: abandoned with no ack, then pending requests re-arbitrate
    dbus_addr = 32'h0000_0400; dbus_read = 1'b1; data_bus_stall = 1'b1;
    ibus_addr = 32'h1E00_0050; ibus_read = 1'b1;
    step();
    @(negedge clk);
    chk1("rstmid_granted", dev_access_read, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; data_bus_stall = 1'b0; dev_rd = 32'h0000_0077;
    push_bus(32'h0000_0400, 1'b1, 1'b0, 32'h0); q_d.push_back(32'h0000_0077);
    @(negedge clk);
    chk1("rstmid_dev_read", dev_access_read, 1'b0);
    chk1("rstmid_dev_write", dev_access_write, 1'b0);
    chk1("rstmid_dbus_ack", dbus_ack, 1'b0);
    chk("rstmid_dbus_rdata", dbus_rdata, 32'h0);
    chk("rstmid_ibus_rdata", ibus_rdata, 32'h0);
    step();
    @(negedge clk);
    chk("rstmid_regrant_addr", dev_access_addr, 32'h0000_0400);
    step();
    dbus_read = 1'b0; dev_rd = 32'h0000_0088;
    push_bus(32'h1E00_0050, 1'b1, 1'b0, 32'h0); q_i.push_back(32'h0000_0088);
    step();
    step();
    ibus_read = 1'b0;
    repeat (3) step();

    chk("scoreboard_drain", 32'(q_bus.size() + q_i.size() + q_d.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
